// File: rtl/control_mdu_seq.sv
// ID-stage control unit for RV32IM: decodes into a registered ID/EX control bundle and
// sequences multi-cycle M-extension operations through a start/done/abort handshake.
module control_mdu_seq #(
    parameter int unsigned ALU_FUN_W   = 6,
    parameter bit          MDU_EN      = 1'b1,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid_ctl_i,
    input  logic [2:0]           instr_funct3_ctl_i,
    input  logic [6:0]           instr_funct7_ctl_i,
    input  logic [6:0]           instr_opcode_ctl_i,
    input  logic                 is_r_type_ctl_i,
    input  logic                 is_i_type_ctl_i,
    input  logic                 is_s_type_ctl_i,
    input  logic                 is_b_type_ctl_i,
    input  logic                 is_u_type_ctl_i,
    input  logic                 is_j_type_ctl_i,
    input  logic                 flush_ctl_i,
    input  logic                 stall_ex_ctl_i,
    input  logic                 mdu_done_ctl_i,
    output logic [1:0]           pc_sel_ctl_o,
    output logic                 op1sel_ctl_o,
    output logic [1:0]           op2sel_ctl_o,
    output logic [1:0]           wb_sel_ctl_o,
    output logic                 pc4_sel_ctl_o,
    output logic                 mem_wr_ctl_o,
    output logic                 cpr_en_ctl_o,
    output logic                 rf_en_ctl_o,
    output logic [ALU_FUN_W-1:0] alu_fun_ctl_o,
    output logic                 mdu_start_ctl_o,
    output logic [2:0]           mdu_op_ctl_o,
    output logic                 mdu_abort_ctl_o,
    output logic                 stall_id_ctl_o,
    output logic                 illegal_ctl_o,
    output logic                 mdu_timeout_ctl_o
);

    localparam int unsigned CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MDU_TIMEOUT - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_SLL  = 6'b000010;
    localparam logic [5:0] ALU_SRL  = 6'b000100;
    localparam logic [5:0] ALU_SRA  = 6'b000110;
    localparam logic [5:0] ALU_OR   = 6'b001000;
    localparam logic [5:0] ALU_AND  = 6'b010000;
    localparam logic [5:0] ALU_XOR  = 6'b100000;
    localparam logic [5:0] ALU_SLT  = 6'b101001;
    localparam logic [5:0] ALU_SLTU = 6'b110001;

    typedef enum logic [0:0] {S_RUN, S_WAIT} state_e;

    typedef struct packed {
        logic [1:0]           pc_sel;
        logic                 op1sel;
        logic [1:0]           op2sel;
        logic [1:0]           wb_sel;
        logic                 pc4_sel;
        logic                 mem_wr;
        logic                 cpr_en;
        logic                 rf_en;
        logic [ALU_FUN_W-1:0] alu_fun;
    } ctrl_t;

    function automatic ctrl_t mk(input logic [1:0] pc, input logic o1, input logic [1:0] o2,
                                 input logic [1:0] wb, input logic p4, input logic mw,
                                 input logic cp, input logic rf, input logic [5:0] alu);
        ctrl_t c;
        c.pc_sel  = pc;
        c.op1sel  = o1;
        c.op2sel  = o2;
        c.wb_sel  = wb;
        c.pc4_sel = p4;
        c.mem_wr  = mw;
        c.cpr_en  = cp;
        c.rf_en   = rf;
        c.alu_fun = ALU_FUN_W'(alu);
        return c;
    endfunction

    // alt selects SUB/SRA over ADD/SRL
    function automatic logic [5:0] alu_code(input logic alt, input logic [2:0] f3);
        logic [5:0] a;
        a = ALU_ADD;
        casez ({alt, f3})
            4'b0000: a = ALU_ADD;
            4'b1000: a = ALU_SUB;
            4'b?001: a = ALU_SLL;
            4'b?010: a = ALU_SLT;
            4'b?011: a = ALU_SLTU;
            4'b?100: a = ALU_XOR;
            4'b0101: a = ALU_SRL;
            4'b1101: a = ALU_SRA;
            4'b?110: a = ALU_OR;
            4'b?111: a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic [2:0]       mdu_op_q, mdu_op_d;
    logic             timeout_q, timeout_d;
    logic             start_c, abort_c, stall_id_c;

    ctrl_t            dec;
    logic             dec_ok;
    logic             is_mop;
    logic             done_eff;

    logic [2:0] f3;
    logic [6:0] f7;
    assign f3 = instr_funct3_ctl_i;
    assign f7 = instr_funct7_ctl_i;

    // Combinational instruction decode (base ISA only; M-ops handled by the FSM)
    always_comb begin
        dec    = '0;
        dec_ok = 1'b0;
        is_mop = (instr_opcode_ctl_i == OPC_OP) && is_r_type_ctl_i && (f7 == 7'b0000001);
        case (instr_opcode_ctl_i)
            OPC_OP: begin
                if (is_r_type_ctl_i && ((f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))))) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b00, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, alu_code(f7[5], f3));
                end
            end
            OPC_LOAD: begin
                if (is_i_type_ctl_i && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111)) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
                end
            end
            OPC_IMM: begin
                if (is_i_type_ctl_i && ((f3 == 3'b001) ? (f7 == 7'b0000000) :
                    (f3 == 3'b101) ? ((f7 == 7'b0000000) || (f7 == 7'b0100000)) : 1'b1)) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1,
                                alu_code((f3 == 3'b101) && f7[5], f3));
                end
            end
            OPC_JALR: begin
                if (is_i_type_ctl_i && (f3 == 3'b000)) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD);
                end
            end
            OPC_STORE: begin
                if (is_s_type_ctl_i && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010))) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD);
                end
            end
            OPC_BRANCH: begin
                if (is_b_type_ctl_i && (f3 != 3'b010) && (f3 != 3'b011)) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b01, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
                end
            end
            OPC_AUIPC: begin
                if (is_u_type_ctl_i) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b00, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
                end
            end
            OPC_LUI: begin
                if (is_u_type_ctl_i) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
                end
            end
            OPC_JAL: begin
                if (is_j_type_ctl_i) begin
                    dec_ok = 1'b1;
                    dec    = mk(2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
                end
            end
            default: begin
                dec_ok = 1'b0;
            end
        endcase
    end

    assign done_eff = mdu_done_ctl_i | pend_q;

    // Next-state, bundle register and handshake control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        mdu_op_d   = mdu_op_q;
        timeout_d  = timeout_q;
        start_c    = 1'b0;
        abort_c    = 1'b0;
        stall_id_c = 1'b0;
        case (state_q)
            S_RUN: begin
                stall_id_c = instr_valid_ctl_i && is_mop && MDU_EN && !flush_ctl_i;
                if (flush_ctl_i) begin
                    ctrl_d    = '0;
                    illegal_d = 1'b0;
                end else if (!stall_ex_ctl_i) begin
                    ctrl_d    = '0;
                    illegal_d = 1'b0;
                    if (instr_valid_ctl_i) begin
                        if (is_mop && MDU_EN) begin
                            start_c  = 1'b1;
                            mdu_op_d = f3;
                            cnt_d    = '0;
                            pend_d   = 1'b0;
                            state_d  = S_WAIT;
                        end else if (dec_ok) begin
                            ctrl_d = dec;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                stall_id_c = 1'b1;
                if (flush_ctl_i) begin
                    abort_c    = 1'b1;
                    ctrl_d     = '0;
                    illegal_d  = 1'b0;
                    pend_d     = 1'b0;
                    stall_id_c = 1'b0;
                    state_d    = S_RUN;
                end else if (stall_ex_ctl_i) begin
                    pend_d = pend_q | mdu_done_ctl_i;
                end else if (done_eff) begin
                    ctrl_d     = mk(2'b00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
                    illegal_d  = 1'b0;
                    pend_d     = 1'b0;
                    stall_id_c = 1'b0;
                    state_d    = S_RUN;
                end else if (cnt_q == CNT_MAX) begin
                    abort_c    = 1'b1;
                    timeout_d  = 1'b1;
                    ctrl_d     = '0;
                    illegal_d  = 1'b0;
                    stall_id_c = 1'b0;
                    state_d    = S_RUN;
                end else begin
                    ctrl_d    = '0;
                    illegal_d = 1'b0;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            mdu_op_q  <= 3'b000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            mdu_op_q  <= mdu_op_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_sel_ctl_o      = ctrl_q.pc_sel;
    assign op1sel_ctl_o      = ctrl_q.op1sel;
    assign op2sel_ctl_o      = ctrl_q.op2sel;
    assign wb_sel_ctl_o      = ctrl_q.wb_sel;
    assign pc4_sel_ctl_o     = ctrl_q.pc4_sel;
    assign mem_wr_ctl_o      = ctrl_q.mem_wr;
    assign cpr_en_ctl_o      = ctrl_q.cpr_en;
    assign rf_en_ctl_o       = ctrl_q.rf_en;
    assign alu_fun_ctl_o     = ctrl_q.alu_fun;
    assign illegal_ctl_o     = illegal_q;
    assign mdu_op_ctl_o      = mdu_op_q;
    assign mdu_timeout_ctl_o = timeout_q;
    // Handshake strobes are held low while reset is asserted
    assign mdu_start_ctl_o   = start_c & rst_n;
    assign mdu_abort_ctl_o   = abort_c & rst_n;
    assign stall_id_ctl_o    = stall_id_c & rst_n;

endmodule

// File: tb/tb_control_mdu_seq.sv
// Directed bench for control_mdu_seq: decode table, MDU handshake, timeout, flush, stall and reset.
module tb_control_mdu_seq;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    localparam logic [5:0] TR = 6'b100000, TI = 6'b010000, TS = 6'b001000;
    localparam logic [5:0] TB = 6'b000100, TU = 6'b000010, TJ = 6'b000001;

    localparam logic [5:0] A_ADD = 6'b000000, A_SUB = 6'b000001, A_SRA = 6'b000110;
    localparam logic [5:0] A_AND = 6'b010000, A_SLT = 6'b101001, A_SLTU = 6'b110001;

    logic clk = 1'b0;
    logic rst_n;
    logic valid, flush, stall_ex, done;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [5:0] ty;

    logic [1:0] pc_sel, op2, wb;
    logic       op1, pc4, mw, cpr, rf, start, abort, stall, ill, tmo;
    logic [5:0] alu;
    logic [2:0] mop;

    logic [1:0] n_pc_sel, n_op2, n_wb;
    logic       n_op1, n_pc4, n_mw, n_cpr, n_rf, n_start, n_abort, n_stall, n_ill, n_tmo;
    logic [5:0] n_alu;
    logic [2:0] n_mop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_mdu_seq #(.ALU_FUN_W(6), .MDU_EN(1'b1), .MDU_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_ctl_i(valid),
        .instr_funct3_ctl_i(f3), .instr_funct7_ctl_i(f7), .instr_opcode_ctl_i(opc),
        .is_r_type_ctl_i(ty[5]), .is_i_type_ctl_i(ty[4]), .is_s_type_ctl_i(ty[3]),
        .is_b_type_ctl_i(ty[2]), .is_u_type_ctl_i(ty[1]), .is_j_type_ctl_i(ty[0]),
        .flush_ctl_i(flush), .stall_ex_ctl_i(stall_ex), .mdu_done_ctl_i(done),
        .pc_sel_ctl_o(pc_sel), .op1sel_ctl_o(op1), .op2sel_ctl_o(op2), .wb_sel_ctl_o(wb),
        .pc4_sel_ctl_o(pc4), .mem_wr_ctl_o(mw), .cpr_en_ctl_o(cpr), .rf_en_ctl_o(rf),
        .alu_fun_ctl_o(alu), .mdu_start_ctl_o(start), .mdu_op_ctl_o(mop),
        .mdu_abort_ctl_o(abort), .stall_id_ctl_o(stall), .illegal_ctl_o(ill),
        .mdu_timeout_ctl_o(tmo)
    );

    control_mdu_seq #(.ALU_FUN_W(6), .MDU_EN(1'b0), .MDU_TIMEOUT(8)) dut_n (
        .clk(clk), .rst_n(rst_n), .instr_valid_ctl_i(valid),
        .instr_funct3_ctl_i(f3), .instr_funct7_ctl_i(f7), .instr_opcode_ctl_i(opc),
        .is_r_type_ctl_i(ty[5]), .is_i_type_ctl_i(ty[4]), .is_s_type_ctl_i(ty[3]),
        .is_b_type_ctl_i(ty[2]), .is_u_type_ctl_i(ty[1]), .is_j_type_ctl_i(ty[0]),
        .flush_ctl_i(flush), .stall_ex_ctl_i(stall_ex), .mdu_done_ctl_i(done),
        .pc_sel_ctl_o(n_pc_sel), .op1sel_ctl_o(n_op1), .op2sel_ctl_o(n_op2), .wb_sel_ctl_o(n_wb),
        .pc4_sel_ctl_o(n_pc4), .mem_wr_ctl_o(n_mw), .cpr_en_ctl_o(n_cpr), .rf_en_ctl_o(n_rf),
        .alu_fun_ctl_o(n_alu), .mdu_start_ctl_o(n_start), .mdu_op_ctl_o(n_mop),
        .mdu_abort_ctl_o(n_abort), .stall_id_ctl_o(n_stall), .illegal_ctl_o(n_ill),
        .mdu_timeout_ctl_o(n_tmo)
    );

    function automatic logic [16:0] bun(input logic [1:0] p, input logic o1, input logic [1:0] o2,
                                        input logic [1:0] w, input logic p4, input logic m,
                                        input logic c, input logic r, input logic [5:0] a);
        return {p, o1, o2, w, p4, m, c, r, a};
    endfunction

    function automatic logic [16:0] act();
        return {pc_sel, op1, op2, wb, pc4, mw, cpr, rf, alu};
    endfunction

    function automatic logic [16:0] n_act();
        return {n_pc_sel, n_op1, n_op2, n_wb, n_pc4, n_mw, n_cpr, n_rf, n_alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic v, input logic [6:0] f7v, input logic [2:0] f3v,
                         input logic [6:0] op, input logic [5:0] t);
        valid = v;
        f7    = f7v;
        f3    = f3v;
        opc   = op;
        ty    = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        stall_ex = 1'b0;
        done = 1'b0;
        set_i(1'b0, 7'h00, 3'b000, 7'h00, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bundle", 32'(act()), 32'(0));
        chk("rst_ill", 32'(ill), 32'(0));
        chk("rst_start", 32'(start), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_tmo", 32'(tmo), 32'(0));
        chk("rst_mop", 32'(mop), 32'(0));
        rst_n = 1'b1;

        // Base-ISA decode, one-cycle bundle latency
        set_i(1'b1, 7'h00, 3'b000, OP_R, TR); tick();
        chk("add", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD)));
        chk("add_ill", 32'(ill), 32'(0));
        set_i(1'b1, 7'h20, 3'b000, OP_R, TR); tick();
        chk("sub", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_SUB)));
        set_i(1'b1, 7'h00, 3'b111, OP_R, TR); tick();
        chk("and", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_AND)));
        set_i(1'b1, 7'h00, 3'b010, OP_R, TR); tick();
        chk("slt", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_SLT)));
        set_i(1'b1, 7'h20, 3'b101, OP_I, TI); tick();
        chk("srai", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_SRA)));
        set_i(1'b1, 7'h55, 3'b011, OP_I, TI); tick();
        chk("sltiu", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_SLTU)));
        set_i(1'b1, 7'h00, 3'b010, OP_LD, TI); tick();
        chk("lw", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD)));
        set_i(1'b1, 7'h00, 3'b000, OP_JR, TI); tick();
        chk("jalr", 32'(act() >> 6), 32'(bun(2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, A_ADD) >> 6));
        set_i(1'b1, 7'h00, 3'b001, OP_BR, TB); tick();
        chk("bne", 32'(act() >> 6), 32'(bun(2'b01, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD) >> 6));
        set_i(1'b1, 7'h00, 3'b000, OP_AUI, TU); tick();
        chk("auipc", 32'(act() >> 6), 32'(bun(2'b00, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD) >> 6));
        set_i(1'b1, 7'h00, 3'b000, OP_LUI, TU); tick();
        chk("lui", 32'(act() >> 6), 32'(bun(2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD) >> 6));
        set_i(1'b1, 7'h00, 3'b000, OP_JAL, TJ); tick();
        chk("jal", 32'(act() >> 6), 32'(bun(2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD) >> 6));

        // Illegal encodings and invalid slot
        set_i(1'b1, 7'h00, 3'b000, 7'h7f, TR); tick();
        chk("ill_opc_bundle", 32'(act()), 32'(0));
        chk("ill_opc_flag", 32'(ill), 32'(1));
        set_i(1'b1, 7'h20, 3'b001, OP_R, TR); tick();
        chk("ill_f7_flag", 32'(ill), 32'(1));
        set_i(1'b0, 7'h00, 3'b000, OP_R, TR); tick();
        chk("inv_bundle", 32'(act()), 32'(0));
        chk("inv_ill", 32'(ill), 32'(0));

        // MUL with done in the fourth wait cycle
        set_i(1'b1, 7'h01, 3'b000, OP_R, TR); #1;
        chk("mul_start", 32'(start), 32'(1));
        chk("mul_stall", 32'(stall), 32'(1));
        chk("mul_n_start", 32'(n_start), 32'(0));
        chk("mul_n_stall", 32'(n_stall), 32'(0));
        tick();
        chk("mul_c1_start", 32'(start), 32'(0));
        chk("mul_c1_stall", 32'(stall), 32'(1));
        chk("mul_c1_bundle", 32'(act()), 32'(0));
        chk("mul_n_ill", 32'(n_ill), 32'(1));
        chk("mul_n_bundle", 32'(n_act()), 32'(0));
        tick(); tick(); tick();
        done = 1'b1; #1;
        chk("mul_done_stall", 32'(stall), 32'(0));
        tick();
        done = 1'b0;
        chk("mul_result", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD)));
        chk("mul_result_ill", 32'(ill), 32'(0));
        set_i(1'b0, 7'h00, 3'b000, OP_R, TR); #1;
        chk("mul_after_start", 32'(start), 32'(0));

        // DIV with no done: abort at cycle 8
        set_i(1'b1, 7'h01, 3'b100, OP_R, TR); #1;
        chk("div_start", 32'(start), 32'(1));
        tick();
        chk("div_mop", 32'(mop), 32'(3'b100));
        repeat (6) tick();
        chk("div_c7_abort", 32'(abort), 32'(0));
        tick();
        chk("div_c8_abort", 32'(abort), 32'(1));
        chk("div_c8_tmo", 32'(tmo), 32'(0));
        set_i(1'b0, 7'h00, 3'b000, OP_R, TR);
        tick();
        chk("div_tmo_set", 32'(tmo), 32'(1));
        chk("div_tmo_rf", 32'(rf), 32'(0));
        chk("div_tmo_abort_pulse", 32'(abort), 32'(0));
        tick();
        chk("div_tmo_sticky", 32'(tmo), 32'(1));

        // DIV in WAIT with simultaneous flush and done
        set_i(1'b1, 7'h01, 3'b100, OP_R, TR);
        tick(); tick();
        flush = 1'b1; done = 1'b1;
        set_i(1'b0, 7'h00, 3'b000, OP_R, TR); #1;
        chk("flush_abort", 32'(abort), 32'(1));
        chk("flush_stall", 32'(stall), 32'(0));
        tick();
        chk("flush_bundle", 32'(act()), 32'(0));
        chk("flush_run_abort", 32'(abort), 32'(0));
        chk("flush_run_stall", 32'(stall), 32'(0));
        flush = 1'b0; done = 1'b0;

        // Done arriving during stall_ex is remembered
        set_i(1'b1, 7'h01, 3'b000, OP_R, TR);
        tick();
        stall_ex = 1'b1;
        tick();
        done = 1'b1; #1;
        chk("pend_stall_hold", 32'(stall), 32'(1));
        tick();
        done = 1'b0; stall_ex = 1'b0; #1;
        chk("pend_release", 32'(stall), 32'(0));
        set_i(1'b0, 7'h00, 3'b000, OP_R, TR);
        tick();
        chk("pend_result", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD)));

        // SW held through three stall_ex cycles
        set_i(1'b1, 7'h00, 3'b010, OP_ST, TS); tick();
        chk("sw", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, A_ADD)));
        set_i(1'b1, 7'h00, 3'b000, OP_R, TR);
        stall_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_hold_memwr", 32'(mw), 32'(1));
        end
        stall_ex = 1'b0;
        tick();
        chk("sw_release", 32'(act()), 32'(bun(2'b00, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, A_ADD)));

        // REM: illegal without MDU, then reset during WAIT
        set_i(1'b1, 7'h01, 3'b110, OP_R, TR); #1;
        chk("rem_start", 32'(start), 32'(1));
        chk("rem_n_start", 32'(n_start), 32'(0));
        tick();
        chk("rem_n_ill", 32'(n_ill), 32'(1));
        chk("rem_mop", 32'(mop), 32'(3'b110));
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_bundle", 32'(act()), 32'(0));
        chk("rstw_abort", 32'(abort), 32'(0));
        chk("rstw_start", 32'(start), 32'(0));
        chk("rstw_stall", 32'(stall), 32'(0));
        chk("rstw_tmo", 32'(tmo), 32'(0));
        chk("rstw_mop", 32'(mop), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
